cache_req_gen: RTL and testbench
================================

Name: cache_req_gen

Overview:
- Upstream request sequencer for the direct-mapped tag cache model.
- Generates a programmable strided address stream on the cache's req_valid/req_ready/req_addr handshake.
- Consumes the cache's resp_valid/resp_hit and tracks outstanding requests. Signals completion once every issued request has been answered.
- Produces independent issue/response/hit tallies, which the bench cross-checks against the cache's own hit_count/miss_count.

Parameters:
- ADDR_W, 32, address width; must match the cache's ADDR_W.
- CNT_W, 16, width of the request-count, wrap-length and tally fields.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; launches a run. Sampled only in IDLE or DONE.
- base_addr  in  ADDR_W  first address of the run; latched on start.
- stride  in  ADDR_W  address increment per request; latched on start.
- num_reqs  in  CNT_W  total requests to issue; latched on start.
- wrap_len  in  CNT_W  pattern period in requests; 0 = no wrap; latched on start.
- req_valid  out  1  request to cache.
- req_addr  out  ADDR_W  request address.
- req_ready  in  1  cache accepts the request.
- resp_valid  in  1  cache response strobe.
- resp_hit  in  1  hit flag, qualified by resp_valid.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  high in DONE; held until the next start.
- issued_count  out  CNT_W  handshakes completed in the current run.
- resp_count  out  CNT_W  responses received in the current run.
- hit_total  out  CNT_W  responses with resp_hit=1 in the current run.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset, asynchronous, takes effect immediately, including mid-run:
  - state goes to IDLE.
  - req_valid=0, req_addr=0, busy=0, done=0.
  - issued_count=0, resp_count=0, hit_total=0, err=0, outstanding=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE with start=1:
  - Latch the configuration and clear the three tallies and err.
  - Set the pattern index k=0 and cur_addr=base_addr.
  - If num_reqs=0, go to DONE; done stays/rises on the next cycle.
  - Otherwise go to ISSUE; req_valid=1 and req_addr=base_addr from the next cycle.
- start outside IDLE/DONE is ignored.
- ISSUE, handshake rule:
  - A handshake is req_valid && req_ready on a rising edge.
  - Once raised, req_valid stays high and req_addr stays stable until the handshake.
  - After a handshake, the next address is presented on the following cycle. Back-to-back issue at one request per cycle is supported when req_ready stays 1.
- Address generation: req_addr = base_addr + k*stride, computed incrementally (cur_addr += stride), modulo 2^ADDR_W.
  - With wrap_len≠0: when k+1 == wrap_len, set k to 0 and cur_addr back to base_addr.
  - Otherwise k increments.
- On the handshake that makes issued_count == num_reqs:
  - req_valid=0 on the next cycle.
  - Go to DRAIN.
- outstanding counter:
  - +1 on a handshake, −1 on resp_valid.
  - Both in the same cycle leaves it unchanged.
  - Width CNT_W+1; no saturation is needed because the cache gives 1-cycle response latency.
- resp_valid handling, in any non-IDLE state:
  - resp_count increments.
  - hit_total increments when resp_hit=1.
- resp_valid with outstanding=0, in any state including IDLE/DONE:
  - Set err=1.
  - Do not increment the tallies.
  - outstanding stays 0 (no underflow).
- DRAIN: go to DONE in the cycle after outstanding reaches 0 with resp_count == num_reqs.
- DONE: done=1, busy=0; outputs and tallies hold until start or rst.
- Tallies wrap modulo 2^CNT_W; they cannot exceed num_reqs in legal operation.
- The cache's req_ready is not required to be high in IDLE. The generator never asserts req_valid outside ISSUE.

Test Plan:
- Linear stream, line reuse: base=0x100, stride=4, num_reqs=8, wrap_len=0, req_ready=1 → req_addr 0x100,0x104,…,0x11C on 8 consecutive cycles. After the last response: issued=8, resp=8, hit_total=6 (2 compulsory misses), done=1, err=0.
- Conflict wrap: base=0x0, stride=0x400, wrap_len=2, num_reqs=6 against a 64-line×16B cache → addresses 0,0x400,0,0x400,0,0x400. hit_total=0, resp_count=6, cache miss_count=6.
- Backpressure: same as the first scenario, with req_ready low for 3 cycles on the 3rd request → req_addr holds at 0x108 with req_valid=1 for all 3 cycles. Final tallies match the first scenario.
- Address wrap and zero count:
  - base=0xFFFF_FFF8, stride=8, num_reqs=3 → addresses 0xFFFF_FFF8, 0x0000_0000, 0x0000_0008.
  - Separately, num_reqs=0 → DONE without req_valid ever rising; tallies remain 0.
- Async reset mid-run: assert rst between clock edges after 4 handshakes → req_valid, busy and tallies go to 0 before the next edge. A fresh start reissues from base_addr.
- Spurious response: resp_valid=1 while in IDLE → err=1, resp_count stays 0. err clears on the next start.

Source files
------------

// File: rtl/cache_req_gen.sv
// rtl/cache_req_gen.sv - strided request sequencer with outstanding tracking and response tallies
module cache_req_gen #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  num_reqs,
    input  logic [CNT_W-1:0]  wrap_len,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              resp_valid,
    input  logic              resp_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued_count,
    output logic [CNT_W-1:0]  resp_count,
    output logic [CNT_W-1:0]  hit_total,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE_O = (CNT_W+1)'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, stride_q, cur_addr;
    logic [CNT_W-1:0]  num_q, wrap_q, k;
    logic [CNT_W:0]    outstanding;
    logic              launch, hs, resp_ok, last_hs;

    assign launch  = start && (state == IDLE || state == DONE);
    assign hs      = (state == ISSUE) && req_ready;
    // A response with nothing outstanding is a protocol error and never counts.
    assign resp_ok = resp_valid && (outstanding != '0);
    assign last_hs = hs && (issued_count + ONE == num_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (num_reqs == '0) ? DONE : ISSUE;
            ISSUE:      if (last_hs) state_nxt = DRAIN;
            DRAIN:      if (outstanding == '0 && resp_count == num_q) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_valid = (state == ISSUE);
        req_addr  = cur_addr;
        busy      = (state == ISSUE) || (state == DRAIN);
        done      = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q       <= '0;
            stride_q     <= '0;
            num_q        <= '0;
            wrap_q       <= '0;
            k            <= '0;
            cur_addr     <= '0;
            issued_count <= '0;
            resp_count   <= '0;
            hit_total    <= '0;
            err          <= 1'b0;
            outstanding  <= '0;
        end else begin
            if (launch) begin
                base_q       <= base_addr;
                stride_q     <= stride;
                num_q        <= num_reqs;
                wrap_q       <= wrap_len;
                k            <= '0;
                cur_addr     <= base_addr;
                issued_count <= '0;
                resp_count   <= '0;
                hit_total    <= '0;
                err          <= 1'b0;
            end else begin
                if (hs) begin
                    issued_count <= issued_count + ONE;
                    if (wrap_q != '0 && k + ONE == wrap_q) begin
                        k        <= '0;
                        cur_addr <= base_q;
                    end else begin
                        k        <= k + ONE;
                        cur_addr <= cur_addr + stride_q;
                    end
                end
                if (resp_valid) begin
                    if (!resp_ok) begin
                        err <= 1'b1;
                    end else if (state != IDLE) begin
                        resp_count <= resp_count + ONE;
                        if (resp_hit) hit_total <= hit_total + ONE;
                    end
                end
            end
            case ({hs, resp_ok})
                2'b10:   outstanding <= outstanding + ONE_O;
                2'b01:   outstanding <= outstanding - ONE_O;
                default: outstanding <= outstanding;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_req_gen.sv
// tb/tb_cache_req_gen.sv - bench acting as a 64-line x 16B direct-mapped cache
module tb_cache_req_gen;
    logic        clk = 1'b0;
    logic        rst, start, req_ready, resp_valid, resp_hit;
    logic [31:0] base_addr, stride, req_addr;
    logic [15:0] num_reqs, wrap_len, issued_count, resp_count, hit_total;
    logic        req_valid, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic        lv [64];
    logic [21:0] lt [64];
    int          live_hits;

    cache_req_gen #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
        .num_reqs(num_reqs), .wrap_len(wrap_len), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit), .busy(busy),
        .done(done), .issued_count(issued_count), .resp_count(resp_count),
        .hit_total(hit_total), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cache_access(input logic [31:0] a);
        logic hit;
        hit = lv[a[9:4]] && (lt[a[9:4]] == a[31:10]);
        lv[a[9:4]] = 1'b1;
        lt[a[9:4]] = a[31:10];
        return hit;
    endfunction

    // Hits expected from replaying the ideal address list on an empty cache.
    function automatic int model_hits(input logic [31:0] addrs[$]);
        logic        v [64];
        logic [21:0] t [64];
        int          h = 0;
        foreach (v[j]) begin v[j] = 1'b0; t[j] = '0; end
        foreach (addrs[i]) begin
            if (v[addrs[i][9:4]] && t[addrs[i][9:4]] == addrs[i][31:10]) h++;
            v[addrs[i][9:4]] = 1'b1;
            t[addrs[i][9:4]] = addrs[i][31:10];
        end
        return h;
    endfunction

    // mode: 0 ready always, 1 ready low 3 cycles on 3rd request, 2 random ready
    task automatic run(input logic [31:0] b, input logic [31:0] s, input int num, input int wrap,
                       input int mode, input int abort_at, input int exp_hits_const);
        logic [31:0] exp_addr[$];
        logic [31:0] paddr = '0;
        bit          pend = 1'b0;
        int          n = 0;
        int          low = 0;
        int          hits;
        for (int i = 0; i < num; i++)
            exp_addr.push_back(b + s * 32'((wrap != 0) ? (i % wrap) : i));
        hits = model_hits(exp_addr);
        foreach (lv[j]) lv[j] = 1'b0;
        live_hits = 0;
        @(negedge clk);
        base_addr = b; stride = s; num_reqs = 16'(num); wrap_len = 16'(wrap); start = 1'b1;
        for (int cyc = 0; cyc < 400 + num * 8; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (abort_at != 0 && n == abort_at) begin
                resp_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                check("rst_req_valid", 32'(req_valid), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_issued", 32'(issued_count), 32'd0);
                check("rst_resp", 32'(resp_count), 32'd0);
                check("rst_req_addr", req_addr, 32'd0);
                #1 rst = 1'b0;
                return;
            end
            resp_valid = pend;
            resp_hit   = 1'b0;
            if (pend) begin
                resp_hit = cache_access(paddr);
                if (resp_hit) live_hits++;
            end
            if (cyc == 0) begin
                check("first_valid", 32'(req_valid), 32'(num != 0));
                if (num == 0) check("zero_done", 32'(done), 32'd1);
            end
            if (done) break;
            case (mode)
                0: req_ready = 1'b1;
                1: begin
                    if (n == 2 && low < 3) begin req_ready = 1'b0; low++; end
                    else req_ready = 1'b1;
                end
                default: req_ready = 1'($urandom_range(0, 1));
            endcase
            check("req_valid", 32'(req_valid), 32'(n < num));
            if (req_valid && n < num) check("req_addr", req_addr, exp_addr[n]);
            if (req_valid && req_ready) begin pend = 1'b1; paddr = req_addr; n++; end
            else pend = 1'b0;
        end
        resp_valid = 1'b0;
        check("done", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("issued", 32'(issued_count), 32'(num));
        check("resp", 32'(resp_count), 32'(num));
        check("hits_model", 32'(hit_total), 32'(hits));
        check("hits_cache", 32'(hit_total), 32'(live_hits));
        check("err_clear", 32'(err), 32'd0);
        if (exp_hits_const >= 0) check("hits_plan", 32'(hit_total), 32'(exp_hits_const));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; resp_hit = 1'b0;
        base_addr = '0; stride = '0; num_reqs = '0; wrap_len = '0;
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(req_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_issued", 32'(issued_count), 32'd0);
        rst = 1'b0;

        @(negedge clk); resp_valid = 1'b1; resp_hit = 1'b1;
        @(negedge clk); resp_valid = 1'b0; resp_hit = 1'b0;
        check("spurious_err", 32'(err), 32'd1);
        check("spurious_resp", 32'(resp_count), 32'd0);
        check("spurious_hits", 32'(hit_total), 32'd0);

        run(32'h100, 32'h4, 8, 0, 0, 0, 6);
        run(32'h0, 32'h400, 6, 2, 0, 0, 0);
        run(32'h100, 32'h4, 8, 0, 1, 0, 6);
        run(32'hFFFF_FFF8, 32'h8, 3, 0, 0, 0, -1);
        run(32'h40, 32'h4, 0, 0, 0, 0, 0);
        run(32'h200, 32'h10, 10, 0, 0, 4, -1);
        run(32'h200, 32'h10, 10, 0, 0, 0, -1);
        run(32'h300, 32'h10, 5, 1, 2, 0, -1);

        for (int r = 0; r < 8; r++) begin
            logic [31:0] rb, rs;
            rb = $urandom;
            rs = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 16) * 4);
            run(rb, rs, int'($urandom_range(1, 20)), int'($urandom_range(0, 5)), 2, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
